// File: rtl/hazard_scoreboard.sv
// Load-use hazard unit: per-register countdown scoreboard driving PC/IF-ID enables and ID/EX bubbles.
// Also squashes producers on branch flush, honours memory freeze and counts stall cycles.
module hazard_scoreboard #(
   parameter int REG_ADDR_W  = 3,
   parameter int LOAD_LAT    = 1,
   parameter int ZERO_REG_EN = 0,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs,
   input  logic                  id_rs_rd,
   input  logic [REG_ADDR_W-1:0] id_rt,
   input  logic                  id_rt_rd,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_regwrite,
   input  logic                  id_is_load,
   input  logic                  flush,
   input  logic                  mem_busy,
   output logic                  stall,
   output logic                  pc_write_en,
   output logic                  ifid_write_en,
   output logic                  idex_bubble,
   output logic [CNT_W-1:0]      stall_count
);

   localparam int NUM_REGS = 2 ** REG_ADDR_W;
   localparam int CW       = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
   localparam logic [CW-1:0]    LAT_V   = CW'(LOAD_LAT);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CW-1:0]         cnt [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;
   logic                  hazard;
   logic                  issue;
   logic                  ex_valid;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_regwrite;
   logic                  squash_ex;

   always_comb begin
      busy = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         busy[r] = (cnt[r] != '0);
      end
      if (ZERO_REG_EN != 0) begin
         busy[0] = 1'b0;
      end
   end

   assign hazard        = id_valid & ((id_rs_rd & busy[id_rs]) | (id_rt_rd & busy[id_rt]));
   assign stall         = hazard & ~flush;
   assign pc_write_en   = ~mem_busy & ~stall;
   assign ifid_write_en = ~mem_busy & ~stall;
   assign idex_bubble   = stall & ~mem_busy;
   assign issue         = id_valid & ~stall & ~flush & ~mem_busy;
   assign squash_ex     = flush & ex_valid & ex_regwrite;

   // A squashed producer's countdown is dropped; a younger issuing writer overrides an older load.
   // NOTE: sequential state uses <= so every register samples pre-edge values, independent of block order.
   always_ff @(posedge clk) begin
      for (int r = 0; r < NUM_REGS; r++) begin
         if (rst) begin
            cnt[r] <= '0;
         end else if ((ZERO_REG_EN != 0) && (r == 0)) begin
            cnt[r] <= '0;
         end else if (squash_ex && (ex_rd == REG_ADDR_W'(r))) begin
            cnt[r] <= '0;
         end else if (issue && id_regwrite && (id_rd == REG_ADDR_W'(r))) begin
            cnt[r] <= id_is_load ? LAT_V : '0;
         end else if (!mem_busy && (cnt[r] != '0)) begin
            cnt[r] <= cnt[r] - CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_valid <= 1'b0;
      end else if (flush) begin
         ex_valid <= 1'b0;
      end else if (!mem_busy) begin
         ex_valid <= issue;
      end
   end

   // NOTE: ex_rd/ex_regwrite are qualified by ex_valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (!flush && !mem_busy) begin
         ex_rd       <= id_rd;
         ex_regwrite <= id_regwrite;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_count <= '0;
      end else if (stall && (stall_count != CNT_MAX)) begin
         stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule
